jtag_tap_ctrl: RTL

IEEE 1149.1-style TAP controller driving the DR-control and instruction-select side of the test interface. Tracks TMS through the 16-state TAP FSM and holds a 4-bit instruction register. Decodes EXTEST / SAMPLE_PRELOAD / MBIST / DEBUG selects and owns the IDCODE and BYPASS data registers. Muxes the active chain's serial output onto TDO.

---
 rtl/jtag_pkg.sv | 37 +++
 rtl/jtag_tap_ctrl_if.sv | 34 +++
 rtl/jtag_tap_fsm.sv | 56 +++++
 rtl/jtag_tap_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP types and constants: state encoding, IR width, opcodes, capture pattern.
// Pure declarations; no logic, latency or flow control.
package jtag_pkg;

    localparam int IR_LEN = 4;

    typedef enum logic [3:0] {
        TAP_TLR       = 4'd0,
        TAP_RTI       = 4'd1,
        TAP_SEL_DR    = 4'd2,
        TAP_CAP_DR    = 4'd3,
        TAP_SHIFT_DR  = 4'd4,
        TAP_EXIT1_DR  = 4'd5,
        TAP_PAUSE_DR  = 4'd6,
        TAP_EXIT2_DR  = 4'd7,
        TAP_UPD_DR    = 4'd8,
        TAP_SEL_IR    = 4'd9,
        TAP_CAP_IR    = 4'd10,
        TAP_SHIFT_IR  = 4'd11,
        TAP_EXIT1_IR  = 4'd12,
        TAP_PAUSE_IR  = 4'd13,
        TAP_EXIT2_IR  = 4'd14,
        TAP_UPD_IR    = 4'd15
    } tap_state_t;

    localparam logic [IR_LEN-1:0] OP_EXTEST         = 4'b0000;
    localparam logic [IR_LEN-1:0] OP_SAMPLE_PRELOAD = 4'b0001;
    localparam logic [IR_LEN-1:0] OP_IDCODE         = 4'b0010;
    localparam logic [IR_LEN-1:0] OP_MBIST          = 4'b1000;
    localparam logic [IR_LEN-1:0] OP_DEBUG          = 4'b1001;
    localparam logic [IR_LEN-1:0] OP_BYPASS         = 4'b1111;

    localparam logic [IR_LEN-1:0] IR_CAPTURE = 4'b0101;

    localparam logic [31:0] IDCODE_DEFAULT = 32'h1801_0A4B;

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// Scan-side signal bundle of the TAP: TMS/TDI, chain returns, strobes, selects and TDO.
// Purely wiring; the master side drives TMS/TDI and chain returns, the slave side is the TAP.
interface jtag_tap_ctrl_if;
    logic tms_i;
    logic tdi_i;
    logic bs_chain_tdo_i;
    logic mbist_tdo_i;
    logic debug_tdo_i;
    logic test_logic_reset_o;
    logic capture_dr_o;
    logic shift_dr_o;
    logic pause_dr_o;
    logic update_dr_o;
    logic extest_select_o;
    logic sample_preload_select_o;
    logic mbist_select_o;
    logic debug_select_o;
    logic tdo_o;
    logic tdo_oe_o;

    modport master (
        output tms_i, tdi_i, bs_chain_tdo_i, mbist_tdo_i, debug_tdo_i,
        input  test_logic_reset_o, capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o,
        input  extest_select_o, sample_preload_select_o, mbist_select_o, debug_select_o,
        input  tdo_o, tdo_oe_o
    );

    modport slave (
        input  tms_i, tdi_i, bs_chain_tdo_i, mbist_tdo_i, debug_tdo_i,
        output test_logic_reset_o, capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o,
        output extest_select_o, sample_preload_select_o, mbist_select_o, debug_select_o,
        output tdo_o, tdo_oe_o
    );
endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state 1149.1 TAP state machine with Moore decodes of the registered state.
// Strobes valid one tck after the TMS edge that enters their state; no backpressure.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck_i,
    input  logic       trst_ni,
    input  logic       tms_i,
    output tap_state_t state_o,
    output tap_state_t state_next_o,
    output logic       tlr_o,
    output logic       capture_dr_o,
    output logic       shift_dr_o,
    output logic       pause_dr_o,
    output logic       update_dr_o
);

    tap_state_t state_q, state_d;

    always_ff @(posedge tck_i) begin
        if (!trst_ni) state_q <= TAP_TLR;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TAP_TLR:      state_d = tms_i ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      state_d = tms_i ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   state_d = tms_i ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   state_d = tms_i ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: state_d = tms_i ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: state_d = tms_i ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: state_d = tms_i ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: state_d = tms_i ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   state_d = tms_i ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   state_d = tms_i ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   state_d = tms_i ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: state_d = tms_i ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: state_d = tms_i ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: state_d = tms_i ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: state_d = tms_i ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   state_d = tms_i ? TAP_SEL_DR   : TAP_RTI;
            default:      state_d = TAP_TLR;
        endcase
    end

    assign state_o      = state_q;
    assign state_next_o = state_d;
    assign tlr_o        = (state_q == TAP_TLR);
    assign capture_dr_o = (state_q == TAP_CAP_DR);
    assign shift_dr_o   = (state_q == TAP_SHIFT_DR);
    assign pause_dr_o   = (state_q == TAP_PAUSE_DR);
    assign update_dr_o  = (state_q == TAP_UPD_DR);

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller: IR shift/latch, instruction decode, IDCODE/BYPASS registers and TDO mux.
// Registers update on tck rise; tdo_o/tdo_oe_o are combinational; no backpressure.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter logic [31:0] IDCODE_VAL = IDCODE_DEFAULT
) (
    input  logic           tck_i,
    input  logic           trst_ni,
    jtag_tap_ctrl_if.slave bus
);

    tap_state_t state_q;
    tap_state_t state_d;

    logic [IR_LEN-1:0] ir_shift_q, ir_shift_d;
    logic [IR_LEN-1:0] ir_q, ir_d;
    logic [31:0]       idcode_q, idcode_d;
    logic              bypass_q, bypass_d;

    logic sel_extest, sel_sample, sel_idcode, sel_mbist, sel_debug, sel_bypass;
    logic tdo;

    jtag_tap_fsm u_fsm (
        .tck_i        (tck_i),
        .trst_ni      (trst_ni),
        .tms_i        (bus.tms_i),
        .state_o      (state_q),
        .state_next_o (state_d),
        .tlr_o        (bus.test_logic_reset_o),
        .capture_dr_o (bus.capture_dr_o),
        .shift_dr_o   (bus.shift_dr_o),
        .pause_dr_o   (bus.pause_dr_o),
        .update_dr_o  (bus.update_dr_o)
    );

    // Decode only the latched IR so selects stay stable while a new opcode shifts in.
    always_comb begin
        sel_extest = 1'b0;
        sel_sample = 1'b0;
        sel_idcode = 1'b0;
        sel_mbist  = 1'b0;
        sel_debug  = 1'b0;
        sel_bypass = 1'b0;
        case (ir_q)
            OP_EXTEST:         sel_extest = 1'b1;
            OP_SAMPLE_PRELOAD: sel_sample = 1'b1;
            OP_IDCODE:         sel_idcode = 1'b1;
            OP_MBIST:          sel_mbist  = 1'b1;
            OP_DEBUG:          sel_debug  = 1'b1;
            default:           sel_bypass = 1'b1;
        endcase
    end

    always_comb begin
        ir_shift_d = ir_shift_q;
        ir_d       = ir_q;
        idcode_d   = idcode_q;
        bypass_d   = bypass_q;

        if (state_q == TAP_CAP_IR)   ir_shift_d = IR_CAPTURE;
        if (state_q == TAP_SHIFT_IR) ir_shift_d = {bus.tdi_i, ir_shift_q[IR_LEN-1:1]};
        if (state_q == TAP_UPD_IR)   ir_d       = ir_shift_q;

        // Landing in TLR drops any partial IR scan and reverts to IDCODE.
        if (state_d == TAP_TLR) begin
            ir_d       = OP_IDCODE;
            ir_shift_d = IR_CAPTURE;
        end

        if (sel_idcode) begin
            if (state_q == TAP_CAP_DR)   idcode_d = IDCODE_VAL;
            if (state_q == TAP_SHIFT_DR) idcode_d = {bus.tdi_i, idcode_q[31:1]};
        end
        if (sel_bypass) begin
            if (state_q == TAP_CAP_DR)   bypass_d = 1'b0;
            if (state_q == TAP_SHIFT_DR) bypass_d = bus.tdi_i;
        end
    end

    always_ff @(posedge tck_i) begin
        if (!trst_ni) begin
            ir_shift_q <= IR_CAPTURE;
            ir_q       <= OP_IDCODE;
            idcode_q   <= IDCODE_VAL;
            bypass_q   <= 1'b0;
        end else begin
            ir_shift_q <= ir_shift_d;
            ir_q       <= ir_d;
            idcode_q   <= idcode_d;
            bypass_q   <= bypass_d;
        end
    end

    always_comb begin
        tdo = 1'b0;
        if (state_q == TAP_SHIFT_IR) begin
            tdo = ir_shift_q[0];
        end else if (state_q == TAP_SHIFT_DR) begin
            if (sel_extest || sel_sample) tdo = bus.bs_chain_tdo_i;
            else if (sel_mbist)           tdo = bus.mbist_tdo_i;
            else if (sel_debug)           tdo = bus.debug_tdo_i;
            else if (sel_idcode)          tdo = idcode_q[0];
            else                          tdo = bypass_q;
        end
    end

    assign bus.tdo_o    = tdo;
    assign bus.tdo_oe_o = (state_q == TAP_SHIFT_IR) || (state_q == TAP_SHIFT_DR);

    assign bus.extest_select_o         = sel_extest;
    assign bus.sample_preload_select_o = sel_sample;
    assign bus.mbist_select_o          = sel_mbist;
    assign bus.debug_select_o          = sel_debug;

endmodule
